lamp_lock_controller: RTL and testbench

LAMP_LOCK_CONTROLLER -- requirements
Module: lamp_lock_controller

---
 rtl/lamp_lock_pkg.sv | 25 ++
 rtl/lamp_lock_controller_if.sv | 34 +++
 rtl/lamp_lock_timer.sv | 34 +++
 rtl/lamp_lock_controller.sv | 131 +++++++++++++
 tb/tb_lamp_lock_controller.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/lamp_lock_pkg.sv
// ============================================================================
// Module      : lamp_lock_pkg
// Description : Shared state encoding and lamp codes for the lamp lock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lamp_lock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_GOT1 = 3'd1,
        ST_GOT2 = 3'd2,
        ST_OPEN = 3'd3,
        ST_LOCK = 3'd4
    } state_t;

    localparam logic [1:0] LAMP_NONE = 2'b00;
    localparam logic [1:0] LAMP_1    = 2'b01;
    localparam logic [1:0] LAMP_2    = 2'b10;
    localparam logic [1:0] LAMP_3    = 2'b11;

endpackage

`default_nettype wire

// File: rtl/lamp_lock_controller_if.sv
// ============================================================================
// Module      : lamp_lock_controller_if
// Description : Lamp press inputs and lock status outputs of the controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lamp_lock_controller_if;

    logic [1:0] in_bit;
    logic       in_valid;
    logic       unlocked;
    logic       lockout;
    logic [3:0] tries_left;

    modport master (
        output in_bit,
        output in_valid,
        input  unlocked,
        input  lockout,
        input  tries_left
    );

    modport slave (
        input  in_bit,
        input  in_valid,
        output unlocked,
        output lockout,
        output tries_left
    );

endinterface

`default_nettype wire

// File: rtl/lamp_lock_timer.sv
// ============================================================================
// Module      : lamp_lock_timer
// Description : 8-bit loadable down-counter with zero flag, shared by the
//               OPEN and LOCK dwell periods.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lamp_lock_timer (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_load,
    input  wire logic [7:0] i_load_val,
    output logic            o_zero
);

    logic [7:0] r_count;

    // Parks at zero when idle so the flag is stable outside OPEN/LOCK.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 8'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != 8'd0) begin
            r_count <= r_count - 8'd1;
        end
    end

    assign o_zero = (r_count == 8'd0);

endmodule

`default_nettype wire

// File: rtl/lamp_lock_controller.sv
// ============================================================================
// Module      : lamp_lock_controller
// Description : Lamp 1-2-3 combination lock with retry budget and lockout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lamp_lock_controller
    import lamp_lock_pkg::*;
#(
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned OPEN_CYCLES    = 8,
    parameter int unsigned LOCKOUT_CYCLES = 16
) (
    input  wire logic              clk,
    input  wire logic              reset,
    lamp_lock_controller_if.slave  bus
);

    localparam logic [3:0] c_max_tries = 4'(MAX_TRIES);
    localparam logic [7:0] c_open_load = 8'(OPEN_CYCLES - 1);
    localparam logic [7:0] c_lock_load = 8'(LOCKOUT_CYCLES - 1);

    state_t     r_state;
    logic [3:0] r_tries;
    logic       r_unlocked;
    logic       r_lockout;

    logic       w_press;
    logic       w_fail;
    logic       w_to_open;
    logic       w_to_lock;
    logic       w_load;
    logic [7:0] w_load_val;
    logic       w_timer_zero;
    state_t     w_fail_state;

    always_comb begin
        w_press      = bus.in_valid && (bus.in_bit != LAMP_NONE);
        w_fail       = 1'b0;
        w_to_open    = 1'b0;
        w_fail_state = ST_IDLE;
        if (w_press) begin
            case (r_state)
                ST_GOT1: w_fail = (bus.in_bit == LAMP_3);
                ST_GOT2: begin
                    w_to_open = (bus.in_bit == LAMP_3);
                    w_fail    = (bus.in_bit != LAMP_3);
                    // A stray lamp 1 costs a try but still counts as a fresh start.
                    if (bus.in_bit == LAMP_1) begin
                        w_fail_state = ST_GOT1;
                    end
                end
                default: ;
            endcase
        end
        w_to_lock  = w_fail && (r_tries == 4'd1);
        w_load     = w_to_open || w_to_lock;
        w_load_val = w_to_open ? c_open_load : c_lock_load;
    end

    lamp_lock_timer u_timer (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_timer_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_tries    <= c_max_tries;
            r_unlocked <= 1'b0;
            r_lockout  <= 1'b0;
        end else if (w_fail) begin
            r_tries <= (r_tries != 4'd0) ? (r_tries - 4'd1) : 4'd0;
            if (w_to_lock) begin
                r_state   <= ST_LOCK;
                r_lockout <= 1'b1;
            end else begin
                r_state <= w_fail_state;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_press && (bus.in_bit == LAMP_1)) begin
                        r_state <= ST_GOT1;
                    end
                end
                ST_GOT1: begin
                    if (w_press && (bus.in_bit == LAMP_2)) begin
                        r_state <= ST_GOT2;
                    end
                end
                ST_GOT2: begin
                    if (w_to_open) begin
                        r_state    <= ST_OPEN;
                        r_unlocked <= 1'b1;
                    end
                end
                ST_OPEN: begin
                    if (w_timer_zero) begin
                        r_state    <= ST_IDLE;
                        r_unlocked <= 1'b0;
                        r_tries    <= c_max_tries;
                    end
                end
                ST_LOCK: begin
                    if (w_timer_zero) begin
                        r_state   <= ST_IDLE;
                        r_lockout <= 1'b0;
                        r_tries   <= c_max_tries;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_unlocked <= 1'b0;
                    r_lockout  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.unlocked   = r_unlocked;
    assign bus.lockout    = r_lockout;
    assign bus.tries_left = r_tries;

endmodule

`default_nettype wire

// File: tb/tb_lamp_lock_controller.sv
// ============================================================================
// Module      : tb_lamp_lock_controller
// Description : Vector-table and scoreboard bench for lamp_lock_controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lamp_lock_controller;
    import lamp_lock_pkg::*;

    typedef struct {
        logic       rst;
        logic       v;
        logic [1:0] b;
        logic       eu;
        logic       el;
        logic [3:0] et;
    } vec_t;

    typedef struct {
        logic       eu;
        logic       el;
        logic [3:0] et;
        int         tag;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    vec_t table_q[$];
    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    lamp_lock_controller_if bus ();

    lamp_lock_controller #(
        .MAX_TRIES      (3),
        .OPEN_CYCLES    (8),
        .LOCKOUT_CYCLES (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic add(input logic r, input logic v, input logic [1:0] b,
                       input logic eu, input logic el, input logic [3:0] et);
        vec_t t;
        t = '{rst: r, v: v, b: b, eu: eu, el: el, et: et};
        table_q.push_back(t);
    endtask

    task automatic add_idle(input int n, input logic eu, input logic el, input logic [3:0] et);
        for (int i = 0; i < n; i++) begin
            add(1'b0, 1'b0, LAMP_NONE, eu, el, et);
        end
    endtask

    task automatic check();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: got empty queue, want one pending expectation");
        end else begin
            e = sb_q.pop_front();
            n_tests++;
            if (bus.unlocked !== e.eu || bus.lockout !== e.el || bus.tries_left !== e.et) begin
                n_fail++;
                $display("FAIL step%0d: got unlocked=%0b lockout=%0b tries_left=%0d, want unlocked=%0b lockout=%0b tries_left=%0d",
                         e.tag, bus.unlocked, bus.lockout, bus.tries_left, e.eu, e.el, e.et);
            end
        end
    endtask

    task automatic apply(input vec_t t, input int tag);
        exp_t e;
        reset        = t.rst;
        bus.in_valid = t.v;
        bus.in_bit   = t.b;
        e = '{eu: t.eu, el: t.el, et: t.et, tag: tag};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check();
    endtask

    task automatic step(input logic r, input logic v, input logic [1:0] b,
                        input logic eu, input logic el, input logic [3:0] et, input int tag);
        vec_t t;
        t = '{rst: r, v: v, b: b, eu: eu, el: el, et: et};
        apply(t, tag);
    endtask

    initial begin
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_bit   = LAMP_NONE;

        // Reset beats a concurrent press; IDLE ignores lamps 2/3 without penalty.
        add(1, 1, LAMP_1, 0, 0, 4'd3);
        add(0, 1, LAMP_2, 0, 0, 4'd3);
        add(0, 1, LAMP_3, 0, 0, 4'd3);

        // Correct sequence, presses inside OPEN ignored, eight open cycles.
        add(0, 1, LAMP_1, 0, 0, 4'd3);
        add(0, 1, LAMP_2, 0, 0, 4'd3);
        add(0, 1, LAMP_3, 1, 0, 4'd3);
        add(0, 1, LAMP_1, 1, 0, 4'd3);
        add(0, 1, LAMP_3, 1, 0, 4'd3);
        add_idle(5, 1, 0, 4'd3);
        add_idle(1, 0, 0, 4'd3);

        // Three failures into a 16-cycle lockout that swallows a correct code.
        add(0, 1, LAMP_1, 0, 0, 4'd3);
        add(0, 1, LAMP_3, 0, 0, 4'd2);
        add(0, 1, LAMP_1, 0, 0, 4'd2);
        add(0, 1, LAMP_2, 0, 0, 4'd2);
        add(0, 1, LAMP_2, 0, 0, 4'd1);
        add(0, 1, LAMP_1, 0, 0, 4'd1);
        add(0, 1, LAMP_3, 0, 1, 4'd0);
        add(0, 1, LAMP_1, 0, 1, 4'd0);
        add(0, 1, LAMP_2, 0, 1, 4'd0);
        add(0, 1, LAMP_3, 0, 1, 4'd0);
        add_idle(12, 0, 1, 4'd0);
        add_idle(1, 0, 0, 4'd3);
        add(0, 1, LAMP_1, 0, 0, 4'd3);
        add(0, 1, LAMP_2, 0, 0, 4'd3);
        add(0, 1, LAMP_3, 1, 0, 4'd3);
        add_idle(7, 1, 0, 4'd3);
        add_idle(1, 0, 0, 4'd3);

        // Repeated lamp 1, gaps and null codes between presses.
        add(0, 1, LAMP_1, 0, 0, 4'd3);
        add(0, 0, LAMP_1, 0, 0, 4'd3);
        add(0, 1, LAMP_1, 0, 0, 4'd3);
        add(0, 1, LAMP_NONE, 0, 0, 4'd3);
        add(0, 1, LAMP_1, 0, 0, 4'd3);
        add(0, 1, LAMP_2, 0, 0, 4'd3);
        add(0, 0, LAMP_3, 0, 0, 4'd3);
        add(0, 1, LAMP_3, 1, 0, 4'd3);
        add_idle(7, 1, 0, 4'd3);
        add_idle(1, 0, 0, 4'd3);

        // Lamp 1 from GOT2 fails into GOT1; tries reload only when OPEN ends.
        add(0, 1, LAMP_1, 0, 0, 4'd3);
        add(0, 1, LAMP_2, 0, 0, 4'd3);
        add(0, 1, LAMP_1, 0, 0, 4'd2);
        add(0, 1, LAMP_2, 0, 0, 4'd2);
        add(0, 1, LAMP_3, 1, 0, 4'd2);
        add_idle(7, 1, 0, 4'd2);
        add_idle(1, 0, 0, 4'd3);

        @(posedge clk);
        #1;
        for (int i = 0; i < table_q.size(); i++) begin
            apply(table_q[i], i);
        end

        // Reset on the fourth OPEN cycle, then a lone lamp 3 must not open.
        step(0, 1, LAMP_1, 0, 0, 4'd3, 1000);
        step(0, 1, LAMP_2, 0, 0, 4'd3, 1001);
        step(0, 1, LAMP_3, 1, 0, 4'd3, 1002);
        step(0, 0, LAMP_NONE, 1, 0, 4'd3, 1003);
        step(0, 0, LAMP_NONE, 1, 0, 4'd3, 1004);
        step(1, 0, LAMP_NONE, 0, 0, 4'd3, 1005);
        step(0, 1, LAMP_3, 0, 0, 4'd3, 1006);
        step(0, 0, LAMP_NONE, 0, 0, 4'd3, 1007);

        // Reset inside LOCK aborts the penalty; the code works straight away.
        step(0, 1, LAMP_1, 0, 0, 4'd3, 1100);
        step(0, 1, LAMP_3, 0, 0, 4'd2, 1101);
        step(0, 1, LAMP_1, 0, 0, 4'd2, 1102);
        step(0, 1, LAMP_3, 0, 0, 4'd1, 1103);
        step(0, 1, LAMP_1, 0, 0, 4'd1, 1104);
        step(0, 1, LAMP_3, 0, 1, 4'd0, 1105);
        step(0, 0, LAMP_NONE, 0, 1, 4'd0, 1106);
        step(1, 1, LAMP_1, 0, 0, 4'd3, 1107);
        step(0, 1, LAMP_1, 0, 0, 4'd3, 1108);
        step(0, 1, LAMP_2, 0, 0, 4'd3, 1109);
        step(0, 1, LAMP_3, 1, 0, 4'd3, 1110);

        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard drain: got %0d pending, want 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
